// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signal bundle for the tri-state bus arbiter.
// Signals:
//   req        - per-requester level request, held for the whole use of the bus
//   gnt        - one-hot or zero enables, bit i drives sel of tri-state buffer i
//   owner      - encoded index of the current or most recent owner
//   bus_busy   - high while a tenure or a turnaround is in progress
//   turnaround - high only during the all-drivers-off gap between tenures
// Modports: master (requester side, drives req) and slave (arbiter side).
interface tristate_bus_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [OW-1:0]    owner;
    logic             bus_busy;
    logic             turnaround;

    modport master (
        output req,
        input  gnt,
        input  owner,
        input  bus_busy,
        input  turnaround
    );

    modport slave (
        input  req,
        output gnt,
        output owner,
        output bus_busy,
        output turnaround
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter producing the buffer enables for a shared tri-state bus.
// At most one buffer is ever enabled, every change of owner passes through at
// least TURN_CYCLES all-off cycles, and an owner is revoked after MAX_HOLD
// cycles only if somebody else is waiting.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset; clears all enables immediately
//   bus   - slave side of tristate_bus_arbiter_if (req in; gnt, owner,
//           bus_busy, turnaround out, all registered)
module tristate_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tristate_bus_arbiter_if.slave bus
);
    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(32'd1);
    localparam logic [TW-1:0] TURN_INIT = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] TURN_ONE  = TW'(32'd1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
    localparam logic [OW-1:0] IDX_ONE   = OW'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t           state_r,    state_s;
    logic [N_REQ-1:0] gnt_r,      gnt_s;
    logic [OW-1:0]    owner_r,    owner_s;
    logic             busy_r,     busy_s;
    logic             turn_r,     turn_s;
    logic [OW-1:0]    ptr_r,      ptr_s;
    logic [HW-1:0]    hold_cnt_r, hold_cnt_s;
    logic [TW-1:0]    turn_cnt_r, turn_cnt_s;

    logic [OW-1:0]    scan_pos_s;
    logic [OW-1:0]    win_idx_s;
    logic             win_found_s;
    logic             owner_req_s;
    logic             others_req_s;
    logic             hold_full_s;
    logic             revoke_s;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [OW-1:0] idx);
        to_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Cyclic priority scan of req starting at the round-robin pointer.
    always_comb begin
        scan_pos_s  = ptr_r;
        win_idx_s   = ptr_r;
        win_found_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_pos_s = OW'((int'(ptr_r) + k) % N_REQ);
            if (!win_found_s && bus.req[scan_pos_s]) begin
                win_idx_s   = scan_pos_s;
                win_found_s = 1'b1;
            end else begin
                win_idx_s   = win_idx_s;
                win_found_s = win_found_s;
            end
        end
    end

    // Tenure-end conditions: owner dropped its request, or its hold budget
    // is spent while someone else is waiting.
    always_comb begin
        owner_req_s  = bus.req[owner_r];
        others_req_s = |(bus.req & ~to_onehot(owner_r));
        hold_full_s  = (hold_cnt_r >= HOLD_MAX);
        revoke_s     = !owner_req_s || (hold_full_s && others_req_s);
    end

    // Next-state and next-output logic for the IDLE/GRANT/TURN sequencer.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        owner_s    = owner_r;
        busy_s     = busy_r;
        turn_s     = turn_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        turn_cnt_s = turn_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s    = ST_GRANT;
                    gnt_s      = to_onehot(win_idx_s);
                    owner_s    = win_idx_s;
                    busy_s     = 1'b1;
                    turn_s     = 1'b0;
                    hold_cnt_s = HOLD_ONE;
                end else begin
                    gnt_s  = '0;
                    busy_s = 1'b0;
                    turn_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (revoke_s) begin
                    state_s    = ST_TURN;
                    gnt_s      = '0;
                    busy_s     = 1'b1;
                    turn_s     = 1'b1;
                    turn_cnt_s = TURN_INIT;
                    hold_cnt_s = '0;
                    ptr_s      = (owner_r == LAST_IDX) ? '0 : owner_r + IDX_ONE;
                end else if (!hold_full_s) begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end else begin
                    // Uncontested owner past its budget: counter saturates.
                    hold_cnt_s = hold_cnt_r;
                end
            end
            ST_TURN: begin
                gnt_s  = '0;
                busy_s = 1'b1;
                if (turn_cnt_r != '0) begin
                    turn_cnt_s = turn_cnt_r - TURN_ONE;
                    turn_s     = 1'b1;
                end else if (win_found_s) begin
                    state_s    = ST_GRANT;
                    gnt_s      = to_onehot(win_idx_s);
                    owner_s    = win_idx_s;
                    turn_s     = 1'b0;
                    hold_cnt_s = HOLD_ONE;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    turn_s  = 1'b0;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                gnt_s      = '0;
                busy_s     = 1'b0;
                turn_s     = 1'b0;
                hold_cnt_s = '0;
                turn_cnt_s = '0;
            end
        endcase
    end

    // State and output registers; reset drops every buffer enable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            owner_r    <= '0;
            busy_r     <= 1'b0;
            turn_r     <= 1'b0;
            ptr_r      <= '0;
            hold_cnt_r <= '0;
            turn_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            owner_r    <= owner_s;
            busy_r     <= busy_s;
            turn_r     <= turn_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            turn_cnt_r <= turn_cnt_s;
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.owner      = owner_r;
    assign bus.bus_busy   = busy_r;
    assign bus.turnaround = turn_r;
endmodule
